// File: rtl/inst_loader_pkg.sv
// -----------------------------------------------------------------------------
// inst_loader_pkg
// Shared definitions for the instruction-memory loader:
//   - state_e      : loader FSM state encoding
//   - LOADER_SYNC  : default frame start marker
//   - HOLD_ENABLE / HOLD_DISABLE : polarity of the cpu_hold output
//   - chk_update() : running checksum update over payload bytes
// -----------------------------------------------------------------------------
package inst_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_CNT_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  localparam logic [7:0] LOADER_SYNC  = 8'hA5;

  localparam logic       HOLD_ENABLE  = 1'b1;
  localparam logic       HOLD_DISABLE = 1'b0;

  // Frame checksum is a plain XOR over every payload byte.
  function automatic logic [7:0] chk_update(input logic [7:0] chk,
                                            input logic [7:0] data);
    return chk ^ data;
  endfunction

endpackage

// File: rtl/inst_loader_timeout.sv
// -----------------------------------------------------------------------------
// inst_loader_timeout
// Idle-cycle counter used by the loader to abandon a stalled frame.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   en_i      : counting enabled (loader is inside a frame); 0 forces count=0
//   clr_i     : activity seen this cycle (byte received); clears the count
//   expired_o : the count reaches TIMEOUT on this clock edge
// expired_o is asserted combinationally on the cycle whose edge would bring
// the count to TIMEOUT, so the loader's state register reacts on exactly the
// TIMEOUT-th idle edge. Activity on that same cycle suppresses it.
// -----------------------------------------------------------------------------
module inst_loader_timeout #(
  parameter int unsigned TIMEOUT = 50000000,
  parameter int unsigned TO_W    = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] TERM  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Next idle count: held at zero outside a frame, cleared by activity,
  // saturating at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = {TO_W{1'b0}};
    end else if (clr_i) begin
      cnt_d = {TO_W{1'b0}};
    end else if (cnt_q != TERM) begin
      cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Idle count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {TO_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && !clr_i && (cnt_q == LIMIT);

endmodule

// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
// Receives a program image over a UART byte stream and writes it into
// instruction memory, keeping the CPU held until a full, checksum-verified
// image is in place.
//
// Frame (big-endian): SYNC_BYTE, CNT_HI, CNT_LO, N*4 payload bytes (MSB of
// each word first), CHK = XOR of all payload bytes. N must be 1..2^ADDR_W.
//
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   rx_valid   : one-cycle strobe, rx_data holds a received byte
//   rx_data    : received byte
//   wr_en      : instruction memory write strobe, one cycle per word
//   wr_addr    : word address of the write
//   wr_data    : instruction word
//   cpu_hold   : 1 = CPU held (fetch disabled)
//   load_done  : image loaded and verified
//   load_err   : frame error (bad count, checksum or timeout)
//
// All outputs are registered and decoded from the next state, so load_done,
// load_err and cpu_hold change on the same edge that consumes the deciding
// byte, and wr_en rises on the edge that consumes a word's last byte.
// -----------------------------------------------------------------------------
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = LOADER_SYNC,
  parameter int unsigned TIMEOUT   = 50000000,
  parameter int unsigned TO_W      = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  // Largest legal word count, one bit wider than the count field so that
  // 2^ADDR_W itself is representable for ADDR_W up to 16.
  localparam logic [16:0]     MAX_WORDS = 17'd1 << ADDR_W;
  localparam logic [ADDR_W:0] WCNT_ONE  = (ADDR_W+1)'(1);

  // FSM
  state_e state_q;
  state_e state_d;

  // Datapath registers
  logic [7:0]        cnt_hi_q,   cnt_hi_d;
  logic [ADDR_W:0]   count_q,    count_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       sr_q,       sr_d;       // first three bytes of a word
  logic [7:0]        chk_q,      chk_d;

  // Output registers
  logic              wr_en_q,     wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [31:0]       wr_data_q,   wr_data_d;
  logic              cpu_hold_q,  cpu_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q,  load_err_d;

  // Decode helpers
  logic [15:0] cnt16_s;
  logic        count_ok_s;
  logic        is_sync_s;
  logic        last_byte_s;
  logic        last_word_s;
  logic        to_en_s;
  logic        to_expired_s;

  assign cnt16_s     = {cnt_hi_q, rx_data};
  assign count_ok_s  = (cnt16_s != 16'd0) && ({1'b0, cnt16_s} <= MAX_WORDS);
  assign is_sync_s   = rx_valid && (rx_data == SYNC_BYTE);
  assign last_byte_s = (byte_idx_q == 2'd3);
  // word_cnt is ADDR_W+1 bits wide so N == 2^ADDR_W compares without wrapping.
  assign last_word_s = ((word_cnt_q + WCNT_ONE) == count_q);
  assign to_en_s     = (state_q == ST_CNT_HI) || (state_q == ST_CNT_LO) ||
                       (state_q == ST_DATA)   || (state_q == ST_CHECK);

  inst_loader_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (to_en_s),
    .clr_i     (rx_valid),
    .expired_o (to_expired_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a received byte always takes priority over timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (is_sync_s) begin
          state_d = ST_CNT_HI;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CNT_HI: begin
        if (rx_valid) begin
          state_d = ST_CNT_LO;
        end else if (to_expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_CNT_HI;
        end
      end
      ST_CNT_LO: begin
        if (rx_valid) begin
          state_d = count_ok_s ? ST_DATA : ST_ERR;
        end else if (to_expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_CNT_LO;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          state_d = (last_byte_s && last_word_s) ? ST_CHECK : ST_DATA;
        end else if (to_expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CHECK: begin
        if (rx_valid) begin
          state_d = (rx_data == chk_q) ? ST_DONE : ST_ERR;
        end else if (to_expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_DONE: begin
        if (is_sync_s) begin
          state_d = ST_CNT_HI;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_ERR: begin
        if (is_sync_s) begin
          state_d = ST_CNT_HI;
        end else begin
          state_d = ST_ERR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output / datapath next values: count capture, word assembly, checksum,
  // write strobe, and status flags decoded from the next state.
  always_comb begin
    cnt_hi_d   = cnt_hi_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    sr_d       = sr_q;
    chk_d      = chk_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      ST_CNT_HI: begin
        if (rx_valid) begin
          cnt_hi_d = rx_data;
        end else begin
          cnt_hi_d = cnt_hi_q;
        end
      end
      ST_CNT_LO: begin
        if (rx_valid) begin
          count_d    = cnt16_s[ADDR_W:0];
          word_cnt_d = {(ADDR_W+1){1'b0}};
          byte_idx_d = 2'd0;
          chk_d      = 8'd0;
        end else begin
          count_d    = count_q;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          sr_d       = {sr_q[15:0], rx_data};
          chk_d      = chk_update(chk_q, rx_data);
          byte_idx_d = byte_idx_q + 2'd1;
          if (last_byte_s) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = word_cnt_q[ADDR_W-1:0];
            wr_data_d  = {sr_q, rx_data};
            word_cnt_d = word_cnt_q + WCNT_ONE;
          end else begin
            word_cnt_d = word_cnt_q;
          end
        end else begin
          sr_d = sr_q;
        end
      end
      default: begin
        chk_d = chk_q;
      end
    endcase

    if (state_d == ST_DONE) begin
      cpu_hold_d  = HOLD_DISABLE;
      load_done_d = 1'b1;
    end else begin
      cpu_hold_d  = HOLD_ENABLE;
      load_done_d = 1'b0;
    end

    if (state_d == ST_ERR) begin
      load_err_d = 1'b1;
    end else begin
      load_err_d = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_hi_q    <= 8'd0;
      count_q     <= {(ADDR_W+1){1'b0}};
      word_cnt_q  <= {(ADDR_W+1){1'b0}};
      byte_idx_q  <= 2'd0;
      sr_q        <= 24'd0;
      chk_q       <= 8'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= {ADDR_W{1'b0}};
      wr_data_q   <= 32'd0;
      cpu_hold_q  <= HOLD_ENABLE;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      cnt_hi_q    <= cnt_hi_d;
      count_q     <= count_d;
      word_cnt_q  <= word_cnt_d;
      byte_idx_q  <= byte_idx_d;
      sr_q        <= sr_d;
      chk_q       <= chk_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule
